alu_op_sequencer: RTL and testbench

- Hardware initiator for the clocked 8-bit ALU (ports A, B, ALU_Sel, ALU_out).
- On a start pulse, latches two operands and sweeps ALU_Sel over a programmable opcode range.
- Samples ALU_out at a fixed dwell per opcode and streams {opcode, result} pairs out through a small ready/valid FIFO.
- Used for on-chip self-test and result logging of the ALU.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_result_fifo.sv | 52 +++++
 rtl/alu_op_sequencer.sv | 116 +++++++++++
 tb/tb_alu_op_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and enums for the ALU operation sequencer and its result FIFO.
package alu_pkg;

  localparam int ALU_DATA_W     = 8;
  localparam int ALU_SEL_W      = 4;
  localparam int ALU_LAT_DEF    = 1;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [3:0] {
    ADD  = 4'd0,  SUB  = 4'd1,  MUL  = 4'd2,  DIV  = 4'd3,
    SHL  = 4'd4,  SHR  = 4'd5,  ROL  = 4'd6,  ROR  = 4'd7,
    MAC  = 4'd8,  AND  = 4'd9,  OR   = 4'd10, XOR  = 4'd11,
    NAND = 4'd12, NOR  = 4'd13, EQ   = 4'd14, LT   = 4'd15
  } alu_op_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    PUSH    = 3'd4,
    DONE    = 3'd5
  } seq_state_t;

endpackage

// File: rtl/alu_result_fifo.sv
// First-word fall-through FIFO (pointer + count) holding {opcode, result} pairs.
module alu_result_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign valid    = (count != '0);
  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign do_pop   = pop && valid;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Drives the clocked ALU through an opcode range and streams {opcode, result} pairs out.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W     = ALU_DATA_W,
  parameter int SEL_W      = ALU_SEL_W,
  parameter int ALU_LAT    = ALU_LAT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] op_a_in,
  input  logic [DATA_W-1:0] op_b_in,
  input  logic [SEL_W-1:0]  first_sel,
  input  logic [SEL_W-1:0]  last_sel,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [SEL_W-1:0]  ALU_Sel,
  input  logic [DATA_W-1:0] ALU_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [SEL_W-1:0]  res_sel,
  output logic [DATA_W-1:0] res_data,
  output logic              busy,
  output logic              done,
  output seq_state_t        dbg_state
);

  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  // Handshake: a result leaves the FIFO on any clock edge where res_valid && res_ready;
  // res_valid never depends on res_ready, and the head stays stable until popped.
  seq_state_t        state, state_nxt;
  logic [SEL_W-1:0]  cur, last_q, hold_sel;
  logic [DATA_W-1:0] hold_data;
  logic [CNT_W-1:0]  wait_cnt;
  logic              fifo_full;
  logic              pop;
  logic              push_ok;
  logic              wait_over;

  assign pop       = res_valid && res_ready;
  assign push_ok   = (state == PUSH) && (!fifo_full || pop);
  assign wait_over = (wait_cnt == CNT_W'(ALU_LAT - 1));
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (wait_over) state_nxt = CAPTURE;
      CAPTURE: state_nxt = PUSH;
      PUSH:    if (push_ok) state_nxt = (cur == last_q) ? DONE : ISSUE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A         <= '0;
      B         <= '0;
      ALU_Sel   <= '0;
      cur       <= '0;
      last_q    <= '0;
      hold_sel  <= '0;
      hold_data <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          A      <= op_a_in;
          B      <= op_b_in;
          cur    <= first_sel;
          last_q <= last_sel;
        end
        ISSUE: begin
          ALU_Sel  <= cur;
          wait_cnt <= '0;
        end
        WAIT: wait_cnt <= wait_cnt + CNT_W'(1);
        // Fixed dwell: the sample is taken ALU_LAT+1 cycles after ALU_Sel moved.
        CAPTURE: begin
          hold_sel  <= cur;
          hold_data <= ALU_out;
        end
        PUSH: if (push_ok && (cur != last_q)) cur <= cur + SEL_W'(1);
        default: ;
      endcase
    end
  end

  alu_result_fifo #(
    .WIDTH (SEL_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_ok),
    .push_data ({hold_sel, hold_data}),
    .pop       (res_ready),
    .pop_data  ({res_sel, res_data}),
    .valid     (res_valid),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural one-cycle-latency ALU.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] op_a_in, op_b_in;
  logic [3:0] first_sel, last_sel;
  logic [7:0] A, B;
  logic [3:0] ALU_Sel;
  logic [7:0] alu_out = 8'h00;
  logic       res_valid, res_ready;
  logic [3:0] res_sel;
  logic [7:0] res_data;
  logic       busy, done;
  seq_state_t dbg_state;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int busy_cyc = 0;
  int got_idx = 0;
  logic [11:0] got_q[$];
  logic [11:0] exp_q[$];
  logic [7:0]  exp_tab [16];

  alu_op_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_a_in   (op_a_in),
    .op_b_in   (op_b_in),
    .first_sel (first_sel),
    .last_sel  (last_sel),
    .A         (A),
    .B         (B),
    .ALU_Sel   (ALU_Sel),
    .ALU_out   (alu_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sel   (res_sel),
    .res_data  (res_data),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // Clock and reference ALU
  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    logic [15:0] p;
    p = a * b;
    case (s)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return p[7:0];
      4'd3:    return (b == 8'd0) ? 8'd0 : a / b;
      4'd4:    return a << 1;
      4'd5:    return a >> 1;
      4'd6:    return {a[6:0], a[7]};
      4'd7:    return {a[0], a[7:1]};
      4'd8:    return p[7:0] + a;
      4'd9:    return a & b;
      4'd10:   return a | b;
      4'd11:   return a ^ b;
      4'd12:   return ~(a & b);
      4'd13:   return ~(a | b);
      4'd14:   return {7'd0, a == b};
      default: return {7'd0, a < b};
    endcase
  endfunction

  always @(posedge clk) alu_out <= alu_f(A, B, ALU_Sel);

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (res_valid && res_ready) got_q.push_back({res_sel, res_data});
      if (done) done_cnt++;
      if (busy) busy_cyc++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_start(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f, input logic [3:0] l);
    @(posedge clk); #1;
    op_a_in = a; op_b_in = b; first_sel = f; last_sel = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, busy, 0);
  endtask

  task automatic add_exp(input logic [3:0] f, input int n);
    logic [3:0] s;
    s = f;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({s, exp_tab[s]});
      s = s + 4'd1;
    end
  endtask

  task automatic check_results(input string tag);
    chk({tag, "_count"}, got_q.size() - got_idx, exp_q.size());
    while (exp_q.size() > 0) begin
      if (got_idx < got_q.size()) begin
        chk({tag, "_entry"}, got_q[got_idx], exp_q[0]);
        got_idx++;
      end
      void'(exp_q.pop_front());
    end
    got_idx = got_q.size();
  endtask

  initial begin
    int d0, b0, n;
    // Hand-computed results for A=0x09, B=0x42, opcodes 0..15
    exp_tab = '{8'h4B, 8'hC7, 8'h52, 8'h00, 8'h12, 8'h04, 8'h12, 8'h84,
                8'h5B, 8'h00, 8'h4B, 8'h4B, 8'hFF, 8'hB4, 8'h00, 8'h01};

    // Reset with random inputs and start held high
    rst_n = 1'b0; res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start = 1'b1;
      op_a_in = 8'($urandom_range(0, 255)); op_b_in = 8'($urandom_range(0, 255));
      first_sel = 4'($urandom_range(0, 15)); last_sel = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    chk("rst_A", A, 0);
    chk("rst_B", B, 0);
    chk("rst_sel", ALU_Sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_state", dbg_state, IDLE);
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_start_ignored", busy, 0);

    // Full sweep, no backpressure
    res_ready = 1'b1;
    d0 = done_cnt; b0 = busy_cyc;
    run_start(8'h09, 8'h42, 4'd0, 4'd15);
    @(negedge clk);
    chk("full_busy", busy, 1);
    chk("full_A", A, 8'h09);
    chk("full_B", B, 8'h42);
    wait_idle(300, "full_timeout");
    add_exp(4'd0, 16);
    check_results("full");
    chk("full_done", done_cnt - d0, 1);
    chk("full_cycles", busy_cyc - b0, 65);

    // Backpressure: FIFO fills, PUSH stalls on opcode 4
    res_ready = 1'b0;
    d0 = done_cnt;
    run_start(8'h09, 8'h42, 4'd0, 4'd7);
    repeat (40) @(negedge clk);
    chk("bp_sel", ALU_Sel, 4);
    chk("bp_busy", busy, 1);
    chk("bp_state", dbg_state, PUSH);
    chk("bp_valid", res_valid, 1);
    chk("bp_head", {res_sel, res_data}, {4'd0, 8'h4B});
    chk("bp_no_done", done_cnt - d0, 0);
    @(posedge clk); #1;
    res_ready = 1'b1;
    wait_idle(300, "bp_timeout");
    add_exp(4'd0, 8);
    check_results("bp");
    chk("bp_done", done_cnt - d0, 1);

    // Wrap-around 14 -> 1
    d0 = done_cnt;
    run_start(8'h09, 8'h42, 4'd14, 4'd1);
    wait_idle(200, "wrap_timeout");
    add_exp(4'd14, 4);
    check_results("wrap");
    chk("wrap_done", done_cnt - d0, 1);

    // Single op with a second start mid-sweep
    d0 = done_cnt;
    run_start(8'h09, 8'h42, 4'd9, 4'd9);
    @(posedge clk); #1;
    op_a_in = 8'hAA; op_b_in = 8'h55; first_sel = 4'd0; last_sel = 4'd15; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("single_A_held", A, 8'h09);
    wait_idle(200, "single_timeout");
    repeat (4) @(negedge clk);
    chk("single_idle", busy, 0);
    add_exp(4'd9, 1);
    check_results("single");
    chk("single_done", done_cnt - d0, 1);

    // Reset after three results, then a clean sweep
    d0 = done_cnt;
    run_start(8'h09, 8'h42, 4'd0, 4'd15);
    n = 0;
    while ((got_q.size() - got_idx) < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_three", got_q.size() - got_idx, 3);
    rst_n = 1'b0;
    #1;
    chk("mid_valid", res_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_sel", ALU_Sel, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_no_done", done_cnt - d0, 0);
    chk("mid_still_empty", res_valid, 0);
    got_idx = got_q.size();
    d0 = done_cnt;
    run_start(8'h09, 8'h42, 4'd0, 4'd15);
    wait_idle(300, "post_timeout");
    add_exp(4'd0, 16);
    check_results("post");
    chk("post_done", done_cnt - d0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
